// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage / register file and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    // request side (issue stage -> unit)
    logic            start;
    logic [2:0]      funct3;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // response side (unit -> register-file write port / issue stage)
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            regwrite;

    modport master (
        output start, funct3, rd_in, rs1_data, rs2_data,
        input  busy, result_valid, result, rd_out, regwrite
    );

    modport slave (
        input  start, funct3, rd_in, rs1_data, rs2_data,
        output busy, result_valid, result, rd_out, regwrite
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Multiplies with a 64-bit unsigned
// shift-add (one multiplier bit per cycle) and divides with restoring
// division (one quotient bit per cycle) on operand magnitudes; the sign is
// applied when the final iteration completes. Divide-by-zero and signed
// overflow bypass the iteration and complete immediately.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // architectural state
    state_t            state_q;
    logic [5:0]        cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_pend_q;     // destination held until completion
    logic [XLEN-1:0]   opnd_q;        // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] work_q;        // {hi,lo}: product or {remainder,quotient}
    logic              neg_main_q;    // negate product / quotient at the end
    logic              neg_rem_q;     // negate remainder at the end
    logic              busy_q;
    logic              valid_q;
    logic              regwrite_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    // request decode
    logic              req_is_div;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              fast_path;
    logic [XLEN-1:0]   fast_result;

    // iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_new;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] step_work_d;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   calc_result_d;

    // decode the incoming request: signedness, magnitudes and the fast path
    always_comb begin
        req_is_div = bus.funct3[2];
        a_signed   = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                     (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
        b_signed   = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) ||
                     (bus.funct3 == F_REM);
        a_neg      = a_signed & bus.rs1_data[XLEN-1];
        b_neg      = b_signed & bus.rs2_data[XLEN-1];
        a_mag      = a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
        b_mag      = b_neg ? (~bus.rs2_data + 1'b1) : bus.rs2_data;

        // DIV and REM share funct3[0]=0; only they can overflow
        div_zero   = req_is_div && (bus.rs2_data == '0);
        div_ovf    = req_is_div && !bus.funct3[0] && (bus.rs1_data == MIN_NEG) &&
                     (bus.rs2_data == '1);
        fast_path  = div_zero || div_ovf;

        fast_result = '0;
        if (div_zero) begin
            // funct3[1] selects remainder
            fast_result = bus.funct3[1] ? bus.rs1_data : '1;
        end else if (div_ovf) begin
            fast_result = bus.funct3[1] ? '0 : MIN_NEG;
        end
    end

    // one iteration step of either engine, plus final sign fix-up
    always_comb begin
        // shift-add: conditionally add multiplicand into the high half, shift right
        mul_sum     = {1'b0, work_q[2*XLEN-1:XLEN]} +
                      (work_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_step    = {mul_sum, work_q[XLEN-1:1]};

        // restoring divide: bring in next dividend bit, subtract if it fits
        div_shift   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_ge      = (div_shift >= {1'b0, opnd_q});
        div_rem_new = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
        div_step    = {div_rem_new, work_q[XLEN-2:0], div_ge};

        step_work_d = op_q[2] ? div_step : mul_step;

        prod_signed = neg_main_q ? (~step_work_d + 1'b1) : step_work_d;
        quo_signed  = neg_main_q ? (~step_work_d[XLEN-1:0] + 1'b1) : step_work_d[XLEN-1:0];
        rem_signed  = neg_rem_q ? (~step_work_d[2*XLEN-1:XLEN] + 1'b1)
                                : step_work_d[2*XLEN-1:XLEN];

        calc_result_d = '0;
        case (op_q)
            F_MUL:                      calc_result_d = prod_signed[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  calc_result_d = prod_signed[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              calc_result_d = quo_signed;
            F_REM, F_REMU:              calc_result_d = rem_signed;
            default:                    calc_result_d = '0;
        endcase
    end

    // control FSM with registered outputs; write-back fields change only on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_pend_q  <= '0;
            opnd_q     <= '0;
            work_q     <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q       <= bus.funct3;
                        rd_pend_q  <= bus.rd_in;
                        cnt_q      <= '0;
                        neg_main_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        // multiplier / dividend goes in the low half of the work register
                        opnd_q     <= req_is_div ? b_mag : a_mag;
                        work_q     <= {{XLEN{1'b0}}, (req_is_div ? a_mag : b_mag)};
                        if (fast_path) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            valid_q    <= 1'b1;
                            regwrite_q <= (bus.rd_in != 5'd0);
                            result_q   <= fast_result;
                            rd_out_q   <= bus.rd_in;
                        end else begin
                            state_q    <= CALC;
                            busy_q     <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    work_q <= step_work_d;
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        valid_q    <= 1'b1;
                        regwrite_q <= (rd_pend_q != 5'd0);
                        result_q   <= calc_result_d;
                        rd_out_q   <= rd_pend_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
    assign bus.regwrite     = regwrite_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed RV32M results, latency,
// fast path, rd=0 write suppression, ignored start, back-to-back and reset abort.
module tb_muldiv_unit;
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // issue one request; returns 1 time unit after the accepting edge
    task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // count edges until result_valid, bounded at 40
    task automatic wait_valid(output int lat, output bit busy_seen);
        lat = 0;
        busy_seen = 1'b0;
        while (bus.result_valid !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.funct3 = 3'b0; bus.rd_in = 5'd0;
        bus.rs1_data = 32'h0; bus.rs2_data = 32'h0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.result_valid); end
        checks++; if (bus.regwrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", bus.regwrite); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
        checks++; if (bus.rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd_out got=%0d exp=0", bus.rd_out); end
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_mul();
        int lat; bit bs;
        start_op(F_MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
        wait_valid(lat, bs);
        checks++; if (bus.result !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", bus.result); end
        checks++; if (lat != 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", lat); end
        checks++; if (bus.rd_out !== 5'd5) begin failures++; $display("FAIL mul_rd_out got=%0d exp=5", bus.rd_out); end
        checks++; if (bus.regwrite !== 1'b1) begin failures++; $display("FAIL mul_regwrite got=%b exp=1", bus.regwrite); end
        @(posedge clk); #1;
        checks++; if (bus.regwrite !== 1'b0) begin failures++; $display("FAIL mul_regwrite_pulse got=%b exp=0", bus.regwrite); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL mul_valid_pulse got=%b exp=0", bus.result_valid); end
        $display("MUL 7 x -3 rd=5 -> %h latency=%0d", bus.result, lat);
    endtask

    task automatic test_high_mul();
        logic [2:0]  f_tab [3] = '{F_MULH, F_MULHU, F_MULHSU};
        logic [31:0] a_tab [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b_tab [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e_tab [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            int lat; bit bs;
            start_op(f_tab[i], a_tab[i], b_tab[i], 5'd1);
            wait_valid(lat, bs);
            checks++; if (bus.result !== e_tab[i]) begin failures++; $display("FAIL highmul_result[%0d] got=%h exp=%h", i, bus.result, e_tab[i]); end
            checks++; if (lat != 32) begin failures++; $display("FAIL highmul_latency[%0d] got=%0d exp=32", i, lat); end
            $display("funct3=%b %h x %h -> %h latency=%0d", f_tab[i], a_tab[i], b_tab[i], bus.result, lat);
        end
    endtask

    task automatic test_div();
        logic [2:0]  f_tab [4] = '{F_DIV, F_REM, F_DIVU, F_REMU};
        logic [31:0] a_tab [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b_tab [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e_tab [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            int lat; bit bs;
            start_op(f_tab[i], a_tab[i], b_tab[i], 5'd2);
            wait_valid(lat, bs);
            checks++; if (bus.result !== e_tab[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, bus.result, e_tab[i]); end
            checks++; if (lat != 32) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=32", i, lat); end
            $display("funct3=%b %h / %h -> %h latency=%0d", f_tab[i], a_tab[i], b_tab[i], bus.result, lat);
        end
    endtask

    task automatic test_special();
        logic [2:0]  f_tab [4] = '{F_DIV, F_REMU, F_DIV, F_REM};
        logic [31:0] a_tab [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] b_tab [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e_tab [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            int lat; bit bs;
            start_op(f_tab[i], a_tab[i], b_tab[i], 5'd3);
            // valid is already high in the cycle following the accepting edge
            wait_valid(lat, bs);
            checks++; if (bus.result !== e_tab[i]) begin failures++; $display("FAIL special_result[%0d] got=%h exp=%h", i, bus.result, e_tab[i]); end
            checks++; if (lat != 0) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=0", i, lat); end
            checks++; if (bs || bus.busy !== 1'b0) begin failures++; $display("FAIL special_busy[%0d] got=%b exp=0", i, bs | bus.busy); end
            $display("fast funct3=%b %h / %h -> %h latency=%0d", f_tab[i], a_tab[i], b_tab[i], bus.result, lat);
        end
    endtask

    task automatic test_rd_zero();
        int lat; bit bs;
        start_op(F_MUL, 32'd3, 32'd4, 5'd0);
        wait_valid(lat, bs);
        checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("FAIL rd0_valid got=%b exp=1", bus.result_valid); end
        checks++; if (bus.result !== 32'd12) begin failures++; $display("FAIL rd0_result got=%h exp=0000000c", bus.result); end
        checks++; if (bus.regwrite !== 1'b0) begin failures++; $display("FAIL rd0_regwrite got=%b exp=0", bus.regwrite); end
        $display("MUL 3 x 4 rd=0 -> %h regwrite=%b", bus.result, bus.regwrite);
    endtask

    task automatic test_ignored_start();
        int lat; bit bs; int extra;
        start_op(F_DIVU, 32'd100, 32'd7, 5'd6);
        repeat (9) begin @(posedge clk); #1; end
        // cycle 10 of the operation: a second request that must be dropped
        bus.start = 1'b1; bus.funct3 = F_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4; bus.rd_in = 5'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_valid(lat, bs);
        checks++; if (bus.result !== 32'd14) begin failures++; $display("FAIL ignore_result got=%h exp=0000000e", bus.result); end
        checks++; if (lat + 10 != 32) begin failures++; $display("FAIL ignore_latency got=%0d exp=32", lat + 10); end
        checks++; if (bus.rd_out !== 5'd6) begin failures++; $display("FAIL ignore_rd_out got=%0d exp=6", bus.rd_out); end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.result_valid === 1'b1 || bus.busy === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL ignore_no_second_op got=%0d exp=0", extra); end
        $display("DIVU 100/7 with ignored start -> %h latency=%0d", bus.result, lat + 10);
    endtask

    task automatic test_back_to_back();
        int lat; bit bs;
        start_op(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        wait_valid(lat, bs);
        checks++; if (bus.result !== 32'hFFFFFFFE) begin failures++; $display("FAIL b2b_first got=%h exp=fffffffe", bus.result); end
        // request during the DONE cycle
        bus.start = 1'b1; bus.funct3 = F_REMU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_in = 5'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", bus.result_valid); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_rise got=%b exp=1", bus.busy); end
        checks++; if (bus.result !== 32'hFFFFFFFE) begin failures++; $display("FAIL b2b_result_held got=%h exp=fffffffe", bus.result); end
        wait_valid(lat, bs);
        checks++; if (bus.result !== 32'd2) begin failures++; $display("FAIL b2b_second got=%h exp=00000002", bus.result); end
        checks++; if (lat != 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        checks++; if (bus.rd_out !== 5'd7) begin failures++; $display("FAIL b2b_rd_out got=%0d exp=7", bus.rd_out); end
        $display("back-to-back REMU 100/7 -> %h latency=%0d", bus.result, lat);
    endtask

    task automatic test_reset_abort();
        int lat; bit bs;
        start_op(F_DIVU, 32'd1000, 32'd3, 5'd8);
        repeat (9) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", bus.result_valid); end
        checks++; if (bus.regwrite !== 1'b0) begin failures++; $display("FAIL abort_regwrite got=%b exp=0", bus.regwrite); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=00000000", bus.result); end
        checks++; if (bus.rd_out !== 5'd0) begin failures++; $display("FAIL abort_rd_out got=%0d exp=0", bus.rd_out); end
        @(negedge clk);
        reset_n = 1'b1;
        start_op(F_DIVU, 32'd100, 32'd7, 5'd3);
        wait_valid(lat, bs);
        checks++; if (bus.result !== 32'd14) begin failures++; $display("FAIL abort_next_result got=%h exp=0000000e", bus.result); end
        checks++; if (lat != 32) begin failures++; $display("FAIL abort_next_latency got=%0d exp=32", lat); end
        $display("after reset abort DIVU 100/7 -> %h latency=%0d", bus.result, lat);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_high_mul();
        test_div();
        test_special();
        test_rd_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute time bound so a stuck design cannot hang the run
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
